// File: rtl/credit_fifo.sv
// Credit-managed receive buffer for the tail of a fixed-latency pipeline.
// Credits reserve a slot per launched operation; results drain in order over valid/ready.
module credit_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             issue_ready,
    input  logic             issue,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    credits,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    credits_q, credits_d;
    logic             overflow_q, overflow_d;
    logic             take, pop, push;

    always_comb begin
        take       = issue && (credits_q != '0);
        pop        = (count_q != '0) && out_ready;
        // A full buffer can still accept when the head leaves in the same cycle
        push       = in_valid && ((count_q < FULL) || pop);

        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        credits_d  = credits_q;
        overflow_d = overflow_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A credit returns only when its result leaves downstream, not on arrival
        case ({take, pop})
            2'b10:   credits_d = credits_q - CW'(1);
            2'b01:   credits_d = credits_q + CW'(1);
            default: credits_d = credits_q;
        endcase

        if (in_valid && !push) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            credits_q  <= FULL;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            credits_q  <= credits_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: occupancy gates every read of it
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    assign issue_ready = (credits_q != '0);
    assign out_valid   = (count_q != '0);
    assign out_data    = mem_q[rd_ptr_q];
    assign credits     = credits_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_credit_fifo.sv
// Directed vector table plus hand-written sequences for credit_fifo (WIDTH=8, DEPTH=4).
module tb_credit_fifo;

    logic       clk;
    logic       reset_n;
    logic       issue_ready;
    logic       issue;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] credits;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       issue;
        logic       in_valid;
        logic [7:0] in_data;
        logic       out_ready;
        logic [2:0] exp_credits;
        logic       exp_ready;
        logic       exp_valid;
        logic       chk_data;
        logic [7:0] exp_data;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [28];

    credit_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .issue_ready (issue_ready),
        .issue       (issue),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .credits     (credits),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Drives one vector before the edge, then samples just after it
    task automatic applyStimulus(input int idx, input vec_t v);
        @(negedge clk);
        issue     = v.issue;
        in_valid  = v.in_valid;
        in_data   = v.in_data;
        out_ready = v.out_ready;
        @(posedge clk);
        #1;
        checkOutput($sformatf("v%0d credits", idx), 32'(credits), 32'(v.exp_credits));
        checkOutput($sformatf("v%0d issue_ready", idx), 32'(issue_ready), 32'(v.exp_ready));
        checkOutput($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'(v.exp_valid));
        checkOutput($sformatf("v%0d overflow", idx), 32'(overflow), 32'(v.exp_ovf));
        if (v.chk_data)
            checkOutput($sformatf("v%0d out_data", idx), 32'(out_data), 32'(v.exp_data));
    endtask

    task automatic pulseReset(input string tag);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput({tag, " credits"}, 32'(credits), 32'd4);
        checkOutput({tag, " issue_ready"}, 32'(issue_ready), 32'd1);
        checkOutput({tag, " out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, " overflow"}, 32'(overflow), 32'd0);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        logic       pv [3];
        logic [7:0] pd [3];
        logic [7:0] expq [$];
        logic [7:0] head;
        logic       take;
        int         issued;
        int         popped;
        int         cycles;

        //           iss iv  data   ordy cred rdy val chk data   ovf
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'hA2, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'hA3, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 8'hA4, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 8'hA2, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 8'hA3, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 8'hA4, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 8'hB1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1, 8'hB1, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 8'hB2, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1, 8'hB1, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 8'hB2, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd1, 1'b1, 1'b1, 1'b1, 8'hB2, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'hB2, 1'b0};
        vecs[20] = '{1'b0, 1'b1, 8'hB3, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'hB2, 1'b0};
        vecs[21] = '{1'b0, 1'b1, 8'hB4, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'hB2, 1'b0};
        vecs[22] = '{1'b0, 1'b1, 8'hB5, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'hB2, 1'b0};
        vecs[23] = '{1'b0, 1'b1, 8'hB6, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 8'hB3, 1'b0};
        vecs[24] = '{1'b0, 1'b1, 8'hFF, 1'b0, 3'd1, 1'b1, 1'b1, 1'b1, 8'hB3, 1'b1};
        vecs[25] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 8'hB4, 1'b1};
        vecs[26] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 8'hB5, 1'b1};
        vecs[27] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 1'b1, 1'b1, 8'hB6, 1'b1};

        reset_n   = 1'b1;
        issue     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;

        $display("[TB] reset check");
        repeat (2) @(negedge clk);
        pulseReset("reset");

        $display("[TB] credit exhaustion, drain, simultaneous events, overflow");
        for (int i = 0; i < 28; i++) applyStimulus(i, vecs[i]);

        // Buffer still holds B6 with overflow set; reset must clear both at once
        @(negedge clk);
        issue     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pulseReset("reset after overflow");

        $display("[TB] random stall pattern through a 3-cycle delay pipeline");
        for (int s = 0; s < 3; s++) begin
            pv[s] = 1'b0;
            pd[s] = 8'h00;
        end
        issued = 0;
        popped = 0;
        cycles = 0;
        while (popped < 100 && cycles < 3000) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    checkOutput("random unexpected pop", 32'(out_valid), 32'd0);
                end else begin
                    head = expq.pop_front();
                    checkOutput($sformatf("random item %0d", popped), 32'(out_data), 32'(head));
                end
                popped++;
            end
            in_valid = pv[2];
            in_data  = pd[2];
            pv[2] = pv[1];
            pd[2] = pd[1];
            pv[1] = pv[0];
            pd[1] = pd[0];
            issue = (issued < 100) && ($urandom_range(0, 3) != 0);
            take  = issue && issue_ready;
            pv[0] = take;
            pd[0] = 8'(issued) ^ 8'h5A;
            if (take) begin
                expq.push_back(pd[0]);
                issued++;
            end
            checkOutput("random credits in range", 32'(credits <= 3'd4), 32'd1);
            cycles++;
        end
        checkOutput("random items drained", 32'(popped), 32'd100);
        checkOutput("random overflow", 32'(overflow), 32'd0);

        $display("[TB] reset mid-operation with two entries held");
        @(negedge clk);
        issue     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        issue    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hC1;
        @(negedge clk);
        in_data  = 8'hC2;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checkOutput("hold out_valid", 32'(out_valid), 32'd1);
        checkOutput("hold credits", 32'(credits), 32'd2);
        checkOutput("hold out_data", 32'(out_data), 32'hC1);
        pulseReset("mid-op reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/credit_fifo.md
Name: credit_fifo

Overview:
- Elastic receive buffer for the output end of a fixed-latency pipeline, such as a delay chain or a registered memory read.
- Grants issue credits upstream so that every launched operation has a slot reserved before it is launched.
- Buffers results as they arrive, whatever the latency, and hands them downstream over a valid/ready handshake.
- Lets an unstallable pipeline feed a consumer that can stall, with no loss and no ordering changes.

Parameters:
WIDTH, 8, data bits per entry
DEPTH, 4, buffer entries and total credits; power of two, >= 2
CW, $clog2(DEPTH+1), derived width of the credit and occupancy counters; not overridable

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
issue_ready  output  1  high when at least one credit is free
issue  input  1  upstream launches one operation; takes effect only when issue_ready is high
in_valid  input  1  a pipeline result arrives this cycle
in_data  input  WIDTH  pipeline result data
out_valid  output  1  buffer non-empty
out_ready  input  1  downstream accepts the head entry
out_data  output  WIDTH  head entry; only meaningful while out_valid is high
credits  output  CW  free credits, range 0..DEPTH
overflow  output  1  sticky error: a result arrived while the buffer was full and was dropped

Behaviour:
- Reset (reset_n low, asynchronous):
  - Read and write pointers = 0, occupancy = 0, credits = DEPTH, overflow = 0.
  - Therefore issue_ready = 1 and out_valid = 0.
  - out_data is don't-care.
- Reset asserted mid-operation:
  - Discards all buffered entries and forgets in-flight operations.
  - The upstream pipeline must be flushed under the same reset.
- Event definitions (all evaluated at posedge):
  - take = issue && issue_ready.
  - pop = out_valid && out_ready.
  - push = in_valid && (occupancy < DEPTH || pop).
- Credit counter:
  - take alone: credits - 1.
  - pop alone: credits + 1.
  - take and pop together: credits unchanged.
  - Neither: credits unchanged.
  - issue while credits = 0 is ignored and leaves credits unchanged.
- issue_ready = (credits != 0); purely combinational from the registered counter.
- Credits measure only launched-but-not-popped operations. Arrival of in_valid does not change them.
- Invariant while upstream honours the credits: credits + in-flight + occupancy = DEPTH.
- Buffer:
  - Circular, AW = log2(DEPTH) pointer bits; pointers wrap DEPTH-1 -> 0.
  - push writes in_data at the write pointer and advances it.
  - pop advances the read pointer.
  - Occupancy: +1 on push only, -1 on pop only, unchanged on both.
- Output path:
  - out_valid = (occupancy != 0).
  - out_data = mem[read pointer], combinational read of registered storage.
  - Latency: in_valid at edge N gives out_valid high after edge N, i.e. visible in cycle N+1.
  - No same-cycle in-to-out bypass.
- Full plus simultaneous events:
  - in_valid while occupancy = DEPTH and pop: accepted; occupancy stays DEPTH.
  - in_valid while occupancy = DEPTH and no pop: data dropped, overflow set to 1.
  - overflow stays 1 until reset and cannot occur if upstream honours the credits.
- Order: strictly FIFO; out_data sequence equals in_data arrival sequence.
- out_valid and out_data must stay stable while out_valid = 1 and out_ready = 0.

Test Plan:
1. Reset check:
   - Stimulus: assert reset_n low mid-cycle, release.
   - Required: credits = 4, issue_ready = 1, out_valid = 0, overflow = 0, immediately, without waiting for a clock edge.
2. Credit exhaustion, DEPTH = 4, out_ready = 0:
   - Stimulus: issue 4 cycles.
   - Required: credits 3, 2, 1, 0; issue_ready = 0.
   - Stimulus: 5th issue.
   - Required: credits stay 0.
   - Stimulus: return results 0xA1..0xA4 via in_valid.
   - Required: occupancy 4, overflow = 0.
3. Drain order:
   - Stimulus: from test 2, raise out_ready.
   - Required: out_data 0xA1, 0xA2, 0xA3, 0xA4 on consecutive cycles; credits return to 4; out_valid then 0.
4. Simultaneous take and pop:
   - Stimulus: issue and pop in the same cycle with credits = 2.
   - Required: credits stay 2.
   - Stimulus: push and pop together at occupancy 4.
   - Required: occupancy stays 4, no overflow.
5. Overflow and wrap-around:
   - Stimulus: force in_valid with 0xFF at occupancy 4, no pop.
   - Required: overflow = 1, 0xFF never appears on out_data.
   - Stimulus: random issue/out_ready stall pattern with a 3-cycle delay pipeline, 100 items.
   - Required: output sequence equals input sequence; credits never exceed 4 or go negative.
6. Reset mid-operation:
   - Stimulus: hold 2 entries, then pulse reset_n low between clock edges.
   - Required: out_valid drops immediately, credits = 4, overflow = 0.
